// File: rtl/laser_pkg.sv
// laser_pkg
//   Shared constants, state encoding, point type and the distance helper used
//   by the LASER target feeder and its optional coverage checker.
package laser_pkg;

  localparam int N_PT      = 40;    // points per LASER run
  localparam int TO_CYC    = 1024;  // WAIT cycles before giving up on DONE
  localparam int RADIUS_SQ = 16;    // coverage radius squared (r = 4)
  localparam int CW        = 4;     // coordinate width
  localparam int AW        = 6;     // point-index / write-address width
  localparam int SW        = 6;     // score width (0..40)
  localparam int TOW       = $clog2(TO_CYC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT,
    ST_SCORE,
    ST_REPORT
  } state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } point_t;

  // Squared Euclidean distance between two grid points. The differences are
  // 5-bit signed; their magnitudes fit in 4 bits, each square is <= 225 and
  // the sum fits in 9 bits.
  function automatic logic [8:0] dist_sq(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                         input logic [CW-1:0] bx, input logic [CW-1:0] by);
    logic signed [CW:0] dx;
    logic signed [CW:0] dy;
    logic [CW-1:0]      mx;
    logic [CW-1:0]      my;
    logic [7:0]         sx;
    logic [7:0]         sy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    mx = dx[CW] ? CW'(-dx) : dx[CW-1:0];
    my = dy[CW] ? CW'(-dy) : dy[CW-1:0];
    sx = 8'(mx) * 8'(mx);
    sy = 8'(my) * 8'(my);
    return 9'(sx) + 9'(sy);
  endfunction

endpackage

// File: rtl/laser_cover_check.sv
// laser_cover_check
//   Combinational: reports whether a point lies within the coverage radius of
//   either of two circle centres.
//   Ports: i_px/i_py point, i_c1x/i_c1y and i_c2x/i_c2y centres,
//          o_covered high when d2 to either centre is <= RADIUS_SQ.
module laser_cover_check
  import laser_pkg::*;
(
  input  logic [CW-1:0] i_px,
  input  logic [CW-1:0] i_py,
  input  logic [CW-1:0] i_c1x,
  input  logic [CW-1:0] i_c1y,
  input  logic [CW-1:0] i_c2x,
  input  logic [CW-1:0] i_c2y,
  output logic          o_covered
);

  logic [8:0] w_d2_c1;
  logic [8:0] w_d2_c2;

  assign w_d2_c1   = dist_sq(i_px, i_py, i_c1x, i_c1y);
  assign w_d2_c2   = dist_sq(i_px, i_py, i_c2x, i_c2y);
  assign o_covered = (w_d2_c1 <= 9'(RADIUS_SQ)) || (w_d2_c2 <= 9'(RADIUS_SQ));

endmodule

// File: rtl/laser_target_feeder.sv
// laser_target_feeder
//   Stimulus/result front end for LASER: holds LASER in reset while idle,
//   streams the 40 stored points one per cycle, waits for DONE (with timeout),
//   captures both centres and optionally scores coverage of the point set.
//   Build option: define LASER_FEED_SCORE_EN to include the SCORE state and
//   coverage scorer; otherwise WAIT goes straight to REPORT and o_res_score=0.
//   Ports:
//     i_clk, i_rst (sync, active high)      clock / reset
//     i_start, i_wr_en/addr/x/y             run start and point-memory writes (IDLE only)
//     o_lrst, o_x, o_y                      LASER reset and streamed point
//     i_done, i_c1x/i_c1y/i_c2x/i_c2y       LASER DONE and centre outputs
//     o_busy, o_res_valid, o_res_c*         status and captured centres
//     o_res_score, o_timeout, o_err         coverage count, no-DONE flag, DONE-in-FEED flag
module laser_target_feeder
  import laser_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [CW-1:0] i_wr_x,
  input  logic [CW-1:0] i_wr_y,
  output logic          o_lrst,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  input  logic          i_done,
  input  logic [CW-1:0] i_c1x,
  input  logic [CW-1:0] i_c1y,
  input  logic [CW-1:0] i_c2x,
  input  logic [CW-1:0] i_c2y,
  output logic          o_busy,
  output logic          o_res_valid,
  output logic [CW-1:0] o_res_c1x,
  output logic [CW-1:0] o_res_c1y,
  output logic [CW-1:0] o_res_c2x,
  output logic [CW-1:0] o_res_c2y,
  output logic [SW-1:0] o_res_score,
  output logic          o_timeout,
  output logic          o_err
);

  localparam logic [AW-1:0]  LAST_PT = AW'(N_PT - 1);
  localparam logic [AW-1:0]  NPT_A   = AW'(N_PT);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYC - 1);

  point_t         r_mem [N_PT];
  state_t         r_state;
  state_t         w_state_next;
  logic [AW-1:0]  r_idx;
  logic [TOW-1:0] r_to_cnt;

  logic w_go;
  logic w_wr_ok;
  logic w_feed;
  logic w_capture;
  logic w_tmo;
  logic w_report;
  logic w_score_done;

  // Point memory: written only while idle, never reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[i_wr_addr] <= '{x: i_wr_x, y: i_wr_y};
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_FEED;
      ST_FEED:   if (r_idx == LAST_PT) w_state_next = ST_WAIT;
      ST_WAIT: begin
`ifdef LASER_FEED_SCORE_EN
        if (i_done) w_state_next = ST_SCORE;
`else
        if (i_done) w_state_next = ST_REPORT;
`endif
        else if (r_to_cnt == TO_LAST) w_state_next = ST_REPORT;
      end
      ST_SCORE:  if (w_score_done) w_state_next = ST_REPORT;
      ST_REPORT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_go      = (r_state == ST_IDLE) && i_start;
    w_wr_ok   = (r_state == ST_IDLE) && i_wr_en && (i_wr_addr < NPT_A);
    w_feed    = (r_state == ST_FEED);
    w_capture = (r_state == ST_WAIT) && i_done;
    w_tmo     = (r_state == ST_WAIT) && !i_done && (r_to_cnt == TO_LAST);
    w_report  = (r_state == ST_REPORT);
  end

  // Registered outputs and feed datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lrst      <= 1'b1;
      o_x         <= '0;
      o_y         <= '0;
      o_busy      <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_c1x   <= '0;
      o_res_c1y   <= '0;
      o_res_c2x   <= '0;
      o_res_c2y   <= '0;
      o_timeout   <= 1'b0;
      o_err       <= 1'b0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
    end else begin
      o_busy      <= (w_state_next != ST_IDLE);
      o_res_valid <= w_report;
      r_to_cnt    <= (r_state == ST_WAIT) ? r_to_cnt + 1'b1 : '0;
      if (w_go) begin
        // Point 0 goes out together with LRST falling; the rest follow.
        o_lrst    <= 1'b0;
        o_x       <= r_mem[0].x;
        o_y       <= r_mem[0].y;
        r_idx     <= AW'(1);
        o_err     <= 1'b0;
        o_timeout <= 1'b0;
        o_res_c1x <= '0;
        o_res_c1y <= '0;
        o_res_c2x <= '0;
        o_res_c2y <= '0;
      end
      if (w_feed) begin
        o_x   <= r_mem[r_idx].x;
        o_y   <= r_mem[r_idx].y;
        r_idx <= r_idx + 1'b1;
        if (i_done) o_err <= 1'b1;
      end
      if (w_capture) begin
        o_res_c1x <= i_c1x;
        o_res_c1y <= i_c1y;
        o_res_c2x <= i_c2x;
        o_res_c2y <= i_c2y;
      end
      if (w_tmo)    o_timeout <= 1'b1;
      if (w_report) o_lrst    <= 1'b1;
    end
  end

`ifdef LASER_FEED_SCORE_EN
  // Scorer: the first point is prefetched on the capture edge so every SCORE
  // cycle evaluates one point; the 40th evaluation happens with r_sidx == N_PT.
  point_t        r_pt;
  logic [AW-1:0] r_sidx;
  logic [SW-1:0] r_score;
  logic          w_cov;

  laser_cover_check u_cover (
    .i_px      (r_pt.x),
    .i_py      (r_pt.y),
    .i_c1x     (o_res_c1x),
    .i_c1y     (o_res_c1y),
    .i_c2x     (o_res_c2x),
    .i_c2y     (o_res_c2y),
    .o_covered (w_cov)
  );

  assign w_score_done = (r_sidx == NPT_A);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pt    <= '0;
      r_sidx  <= '0;
      r_score <= '0;
    end else begin
      if (w_go) r_score <= '0;
      if (w_capture) begin
        r_pt   <= r_mem[0];
        r_sidx <= AW'(1);
      end
      if (r_state == ST_SCORE) begin
        if (w_cov) r_score <= r_score + 1'b1;
        if (r_sidx < NPT_A) begin
          r_pt   <= r_mem[r_sidx];
          r_sidx <= r_sidx + 1'b1;
        end
      end
    end
  end

  assign o_res_score = r_score;
`else
  assign w_score_done = 1'b1;
  assign o_res_score  = '0;
`endif

endmodule

// File: tb/tb_laser_target_feeder.sv
module tb_laser_target_feeder;

`ifdef LASER_FEED_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif
  localparam int EXP_LAT = SCORE_ON ? 42 : 2;
  localparam int TO_LAT  = 1024 + 1;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [5:0] i_wr_addr = '0;
  logic [3:0] i_wr_x = '0;
  logic [3:0] i_wr_y = '0;
  logic       i_done = 1'b0;
  logic [3:0] i_c1x = '0, i_c1y = '0, i_c2x = '0, i_c2y = '0;
  logic       o_lrst, o_busy, o_res_valid, o_timeout, o_err;
  logic [3:0] o_x, o_y, o_res_c1x, o_res_c1y, o_res_c2x, o_res_c2y;
  logic [5:0] o_res_score;

  laser_target_feeder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr), .i_wr_x(i_wr_x), .i_wr_y(i_wr_y),
    .o_lrst(o_lrst), .o_x(o_x), .o_y(o_y), .i_done(i_done),
    .i_c1x(i_c1x), .i_c1y(i_c1y), .i_c2x(i_c2x), .i_c2y(i_c2y),
    .o_busy(o_busy), .o_res_valid(o_res_valid),
    .o_res_c1x(o_res_c1x), .o_res_c1y(o_res_c1y),
    .o_res_c2x(o_res_c2x), .o_res_c2y(o_res_c2y),
    .o_res_score(o_res_score), .o_timeout(o_timeout), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference point set as the bench believes the DUT memory holds it.
  int exp_x[40];
  int exp_y[40];

  // Observations collected by do_run.
  logic [3:0] obs_x[40];
  logic [3:0] obs_y[40];
  int         obs_lrst_low, obs_lat;
  bit         obs_valid;
  logic [3:0] obs_c1x, obs_c1y, obs_c2x, obs_c2y;
  logic [5:0] obs_score;
  logic       obs_timeout, obs_err, obs_err_start;

  // Coverage count straight from the geometric rule.
  function automatic int model_score(int c1x, int c1y, int c2x, int c2y);
    int n = 0;
    for (int k = 0; k < 40; k++) begin
      int d1 = (exp_x[k]-c1x)*(exp_x[k]-c1x) + (exp_y[k]-c1y)*(exp_y[k]-c1y);
      int d2 = (exp_x[k]-c2x)*(exp_x[k]-c2x) + (exp_y[k]-c2y)*(exp_y[k]-c2y);
      if (d1 <= 16 || d2 <= 16) n++;
    end
    return SCORE_ON ? n : 0;
  endfunction

  task automatic load_point(input int addr, input int x, input int y);
    @(negedge i_clk);
    i_wr_en = 1'b1; i_wr_addr = 6'(addr); i_wr_x = 4'(x); i_wr_y = 4'(y);
    if (addr < 40) begin exp_x[addr] = x; exp_y[addr] = y; end
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  // Plays the LASER side of one run and records what the feeder produced.
  task automatic do_run(input int c1x, input int c1y, input int c2x, input int c2y,
                        input bit give_done, input bit err_pulse, input bit poke);
    obs_valid = 0; obs_lat = 0; obs_lrst_low = 0;
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    obs_err_start = o_err;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge i_clk);
      obs_x[k] = o_x; obs_y[k] = o_y;
      if (o_lrst == 1'b0) obs_lrst_low++;
      i_done = err_pulse && (k == 20);
      if (poke && k == 10) begin
        i_start = 1'b1; i_wr_en = 1'b1; i_wr_addr = 6'd0;
        i_wr_x = 4'(exp_x[0] + 1); i_wr_y = 4'(exp_y[0] + 3);
      end else begin
        i_start = 1'b0; i_wr_en = 1'b0;
      end
    end
    i_c1x = 4'(c1x); i_c1y = 4'(c1y); i_c2x = 4'(c2x); i_c2y = 4'(c2y);
    i_done = give_done;
    for (int t = 1; t <= 2000; t++) begin
      @(negedge i_clk);
      i_done = 1'b0;
      if (o_res_valid) begin
        obs_valid = 1; obs_lat = t;
        obs_c1x = o_res_c1x; obs_c1y = o_res_c1y; obs_c2x = o_res_c2x; obs_c2y = o_res_c2y;
        obs_score = o_res_score; obs_timeout = o_timeout; obs_err = o_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    tests_run++;
    if (o_lrst !== 1'b1) begin tests_failed++; $display("FAIL reset_lrst got %b want 1", o_lrst); end
    tests_run++;
    if ({o_busy, o_res_valid, o_timeout, o_err} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_flags got %b want 0000", {o_busy, o_res_valid, o_timeout, o_err});
    end
    tests_run++;
    if ({o_x, o_y, o_res_c1x, o_res_c1y, o_res_c2x, o_res_c2y, o_res_score} !== '0) begin
      tests_failed++; $display("FAIL reset_data got nonzero data outputs x=%0d y=%0d score=%0d", o_x, o_y, o_res_score);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_stream();
    for (int k = 0; k < 40; k++) load_point(k, k % 16, k / 16);
    for (int a = 40; a < 64; a += 7) load_point(a, $urandom_range(0, 15), $urandom_range(0, 15));
    do_run(3, 3, 12, 12, 1, 0, 0);
    tests_run++;
    if (obs_lrst_low != 40) begin tests_failed++; $display("FAIL stream_lrst low cycles %0d want 40", obs_lrst_low); end
    for (int k = 0; k < 40; k++) begin
      tests_run++;
      if (obs_x[k] !== 4'(exp_x[k]) || obs_y[k] !== 4'(exp_y[k])) begin
        tests_failed++; $display("FAIL stream[%0d] got (%0d,%0d) want (%0d,%0d)", k, obs_x[k], obs_y[k], exp_x[k], exp_y[k]);
      end
    end
    tests_run++;
    if (!obs_valid || obs_lat != EXP_LAT) begin
      tests_failed++; $display("FAIL stream_latency valid=%0d lat=%0d want %0d", obs_valid, obs_lat, EXP_LAT);
    end
    tests_run++;
    if (obs_score !== 6'(model_score(3, 3, 12, 12)) || obs_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL stream_score got %0d to=%b want %0d to=0", obs_score, obs_timeout, model_score(3, 3, 12, 12));
    end
    @(negedge i_clk);
    tests_run++;
    if (o_res_valid !== 1'b0 || o_lrst !== 1'b1 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL stream_after valid=%b lrst=%b busy=%b want 0 1 0", o_res_valid, o_lrst, o_busy);
    end
    $display("[TB] stream run lat=%0d score=%0d", obs_lat, obs_score);
  endtask

  task automatic test_score_all();
    for (int k = 0; k < 40; k++) load_point(k, 5, 5);
    do_run(5, 5, 0, 0, 1, 0, 0);
    tests_run++;
    if (obs_score !== 6'(SCORE_ON ? 40 : 0)) begin
      tests_failed++; $display("FAIL score_all got %0d want %0d", obs_score, SCORE_ON ? 40 : 0);
    end
    tests_run++;
    if (!obs_valid || obs_lat != EXP_LAT) begin
      tests_failed++; $display("FAIL score_all_latency valid=%0d lat=%0d want %0d", obs_valid, obs_lat, EXP_LAT);
    end
    $display("[TB] score_all run lat=%0d score=%0d", obs_lat, obs_score);
  endtask

  task automatic test_score_boundary();
    for (int k = 0; k < 40; k++) load_point(k, 15, 15);
    load_point(7, 9, 5);
    load_point(23, 9, 6);
    do_run(5, 5, 0, 0, 1, 0, 0);
    tests_run++;
    if (obs_score !== 6'(SCORE_ON ? 1 : 0)) begin
      tests_failed++; $display("FAIL score_boundary got %0d want %0d", obs_score, SCORE_ON ? 1 : 0);
    end
    tests_run++;
    if ({obs_c1x, obs_c1y, obs_c2x, obs_c2y} !== {4'd5, 4'd5, 4'd0, 4'd0}) begin
      tests_failed++; $display("FAIL score_boundary_centres got (%0d,%0d)(%0d,%0d) want (5,5)(0,0)", obs_c1x, obs_c1y, obs_c2x, obs_c2y);
    end
    $display("[TB] boundary run score=%0d", obs_score);
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int c1x = $urandom_range(0, 15), c1y = $urandom_range(0, 15);
      int c2x = $urandom_range(0, 15), c2y = $urandom_range(0, 15);
      for (int k = 0; k < 40; k++) load_point(k, $urandom_range(0, 15), $urandom_range(0, 15));
      do_run(c1x, c1y, c2x, c2y, 1, 0, 0);
      tests_run++;
      if (obs_score !== 6'(model_score(c1x, c1y, c2x, c2y))) begin
        tests_failed++; $display("FAIL random_score[%0d] got %0d want %0d", it, obs_score, model_score(c1x, c1y, c2x, c2y));
      end
      tests_run++;
      if ({obs_c1x, obs_c1y, obs_c2x, obs_c2y} !== {4'(c1x), 4'(c1y), 4'(c2x), 4'(c2y)}) begin
        tests_failed++; $display("FAIL random_centres[%0d] got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
                                 it, obs_c1x, obs_c1y, obs_c2x, obs_c2y, c1x, c1y, c2x, c2y);
      end
      $display("[TB] random run %0d score=%0d", it, obs_score);
    end
  endtask

  task automatic test_timeout();
    do_run(7, 8, 9, 10, 0, 0, 0);
    tests_run++;
    if (!obs_valid || obs_lat != TO_LAT || obs_timeout !== 1'b1) begin
      tests_failed++; $display("FAIL timeout valid=%0d lat=%0d to=%b want lat %0d to=1", obs_valid, obs_lat, obs_timeout, TO_LAT);
    end
    tests_run++;
    if ({obs_c1x, obs_c1y, obs_c2x, obs_c2y, obs_score} !== '0) begin
      tests_failed++; $display("FAIL timeout_results got c1=(%0d,%0d) c2=(%0d,%0d) score=%0d want all 0",
                               obs_c1x, obs_c1y, obs_c2x, obs_c2y, obs_score);
    end
    $display("[TB] timeout run lat=%0d", obs_lat);
  endtask

  task automatic test_rst_midrun();
    bit seen_valid = 0;
    for (int k = 0; k < 40; k++) load_point(k, $urandom_range(0, 15), $urandom_range(0, 15));
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    repeat (19) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    tests_run++;
    if (o_lrst !== 1'b1 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_midrun lrst=%b busy=%b want 1 0", o_lrst, o_busy);
    end
    repeat (5) begin @(negedge i_clk); if (o_res_valid) seen_valid = 1; end
    tests_run++;
    if (seen_valid) begin tests_failed++; $display("FAIL rst_midrun_valid got a RES_VALID pulse want none"); end
    do_run(1, 2, 3, 4, 1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      tests_run++;
      if (obs_x[k] !== 4'(exp_x[k]) || obs_y[k] !== 4'(exp_y[k])) begin
        tests_failed++; $display("FAIL replay[%0d] got (%0d,%0d) want (%0d,%0d)", k, obs_x[k], obs_y[k], exp_x[k], exp_y[k]);
      end
    end
    $display("[TB] reset mid-run and replay checked");
  endtask

  task automatic test_busy_ignore();
    int bad = 0;
    do_run(2, 2, 13, 13, 1, 0, 1);
    for (int k = 0; k < 40; k++)
      if (obs_x[k] !== 4'(exp_x[k]) || obs_y[k] !== 4'(exp_y[k])) bad++;
    tests_run++;
    if (bad != 0 || obs_lat != EXP_LAT) begin
      tests_failed++; $display("FAIL busy_poke stream mismatches=%0d lat=%0d want 0 and %0d", bad, obs_lat, EXP_LAT);
    end
    do_run(2, 2, 13, 13, 1, 0, 0);
    tests_run++;
    if (obs_x[0] !== 4'(exp_x[0]) || obs_y[0] !== 4'(exp_y[0])) begin
      tests_failed++; $display("FAIL busy_write mem0 got (%0d,%0d) want (%0d,%0d)", obs_x[0], obs_y[0], exp_x[0], exp_y[0]);
    end
    $display("[TB] busy pokes checked");
  endtask

  task automatic test_err();
    do_run(6, 6, 10, 2, 1, 1, 0);
    tests_run++;
    if (obs_err !== 1'b1) begin tests_failed++; $display("FAIL err_set got %b want 1", obs_err); end
    tests_run++;
    if (obs_score !== 6'(model_score(6, 6, 10, 2)) || obs_lat != EXP_LAT) begin
      tests_failed++; $display("FAIL err_run score=%0d lat=%0d want %0d %0d", obs_score, obs_lat, model_score(6, 6, 10, 2), EXP_LAT);
    end
    do_run(6, 6, 10, 2, 1, 0, 0);
    tests_run++;
    if (obs_err_start !== 1'b0 || obs_err !== 1'b0) begin
      tests_failed++; $display("FAIL err_clear start=%b end=%b want 0 0", obs_err_start, obs_err);
    end
    $display("[TB] err run checked");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_score_all();
    test_score_boundary();
    test_random();
    test_timeout();
    test_rst_midrun();
    test_busy_ignore();
    test_err();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
